// File: rtl/mpsoc_apb42ahb3_master_pkg.sv
// -----------------------------------------------------------------------------
// mpsoc_apb42ahb3_master_pkg
// Shared types and encodings for the APB4-slave to AHB3-Lite-master bridge.
//   state_t        : bridge FSM states
//   HTRANS_*       : the only two AHB transfer types the bridge ever drives
//   HSIZE_*        : AHB transfer sizes produced by the strobe decoder
//   HBURST_SINGLE  : the bridge only issues SINGLE transfers
// -----------------------------------------------------------------------------
package mpsoc_apb42ahb3_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage : mpsoc_apb42ahb3_master_pkg

// File: rtl/mpsoc_apb4_strb_decode.sv
// -----------------------------------------------------------------------------
// mpsoc_apb4_strb_decode
// Combinational mapping of an APB4 access (direction + byte strobes) onto a
// single naturally aligned AHB transfer.
//   pwrite_i : APB direction (1 = write)
//   pstrb_i  : APB write byte strobes (ignored for reads)
//   legal_o  : strobe pattern maps onto one aligned byte/half/word transfer
//   hsize_o  : AHB transfer size
//   off_o    : byte offset placed in HADDR[1:0]
// -----------------------------------------------------------------------------
module mpsoc_apb4_strb_decode
  import mpsoc_apb42ahb3_master_pkg::*;
(
  input  logic       pwrite_i,
  input  logic [3:0] pstrb_i,
  output logic       legal_o,
  output logic [2:0] hsize_o,
  output logic [1:0] off_o
);

  always_comb begin
    legal_o = 1'b1;
    hsize_o = HSIZE_WORD;
    off_o   = 2'd0;
    if (pwrite_i) begin
      case (pstrb_i)
        4'b0001: begin hsize_o = HSIZE_BYTE; off_o = 2'd0; end
        4'b0010: begin hsize_o = HSIZE_BYTE; off_o = 2'd1; end
        4'b0100: begin hsize_o = HSIZE_BYTE; off_o = 2'd2; end
        4'b1000: begin hsize_o = HSIZE_BYTE; off_o = 2'd3; end
        4'b0011: begin hsize_o = HSIZE_HALF; off_o = 2'd0; end
        4'b1100: begin hsize_o = HSIZE_HALF; off_o = 2'd2; end
        4'b1111: begin hsize_o = HSIZE_WORD; off_o = 2'd0; end
        // Sparse or empty strobes cannot be expressed as one AHB transfer.
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule : mpsoc_apb4_strb_decode

// File: rtl/mpsoc_apb42ahb3_master.sv
// -----------------------------------------------------------------------------
// mpsoc_apb42ahb3_master
// APB4 slave to AHB3-Lite master bridge. Each APB4 access becomes one AHB
// SINGLE transfer, or an immediate PSLVERR when the strobe pattern is illegal.
// One outstanding transfer, all outputs registered.
//   HCLK, HRESETn          : clock and asynchronous active-low reset
//   PSEL..PWDATA           : APB4 request side (inputs)
//   PRDATA/PREADY/PSLVERR  : APB4 completion side (registered)
//   HADDR..HMASTLOCK       : AHB-Lite master request (registered/constant)
//   HRDATA/HREADY/HRESP    : AHB-Lite response from the slave mux
// -----------------------------------------------------------------------------
module mpsoc_apb42ahb3_master
  import mpsoc_apb42ahb3_master_pkg::*;
#(
  parameter int PADDR_SIZE = 32,
  parameter int HADDR_SIZE = 32,
  parameter int DATA_SIZE  = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  // APB4 slave
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [2:0]            PPROT,
  input  logic [3:0]            PSTRB,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [DATA_SIZE-1:0]  PWDATA,
  output logic [DATA_SIZE-1:0]  PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  // AHB3-Lite master
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [DATA_SIZE-1:0]  HWDATA,
  input  logic [DATA_SIZE-1:0]  HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  generate
    if (DATA_SIZE != 32) begin : g_bad_data_size
      $error("mpsoc_apb42ahb3_master: DATA_SIZE must be 32");
    end
  endgenerate

  // APB address resized to the AHB address width.
  logic [HADDR_SIZE-1:0] paddr_ext;
  generate
    if (PADDR_SIZE >= HADDR_SIZE) begin : g_addr_trunc
      assign paddr_ext = PADDR[HADDR_SIZE-1:0];
      if (PADDR_SIZE > HADDR_SIZE) begin : g_addr_drop
        logic unused_paddr_hi;
        assign unused_paddr_hi = ^PADDR[PADDR_SIZE-1:HADDR_SIZE];
      end
    end else begin : g_addr_zext
      assign paddr_ext = {{(HADDR_SIZE-PADDR_SIZE){1'b0}}, PADDR};
    end
  endgenerate

  // The low address bits come from the strobe decode; PPROT[1] has no AHB
  // counterpart.
  logic unused_inputs;
  assign unused_inputs = ^{PADDR[1:0], PPROT[1]};

  logic       dec_legal;
  logic [2:0] dec_hsize;
  logic [1:0] dec_off;

  mpsoc_apb4_strb_decode u_strb_decode (
    .pwrite_i (PWRITE),
    .pstrb_i  (PSTRB),
    .legal_o  (dec_legal),
    .hsize_o  (dec_hsize),
    .off_o    (dec_off)
  );

  state_t                state_q, state_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [3:0]            hprot_q, hprot_d;
  logic [DATA_SIZE-1:0]  hwdata_q, hwdata_d;
  logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
  logic [DATA_SIZE-1:0]  prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  abort_q, abort_d;

  // PREADY gating keeps a still-held access phase from being re-issued.
  logic start;
  assign start = PSEL & PENABLE & ~pready_q;

  // Master dropped PSEL at some point during the AHB transfer.
  logic abort_now;
  assign abort_now = abort_q | ~PSEL;

  // State and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= HSIZE_WORD;
      hprot_q   <= 4'b0011;
      hwdata_q  <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hsize_q   <= hsize_d;
      hprot_q   <= hprot_d;
      hwdata_q  <= hwdata_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = dec_legal ? ST_ADDR : ST_DONE;
      ST_ADDR: if (HREADY) state_d = ST_DATA;
      ST_DATA: if (HREADY) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values
  always_comb begin
    htrans_d  = htrans_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    hprot_d   = hprot_q;
    hwdata_d  = hwdata_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    abort_d   = abort_q;
    case (state_q)
      ST_IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        abort_d   = 1'b0;
        if (start) begin
          if (dec_legal) begin
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = {paddr_ext[HADDR_SIZE-1:2], dec_off};
            hwrite_d = PWRITE;
            hsize_d  = dec_hsize;
            hprot_d  = {2'b00, PPROT[0], ~PPROT[2]};
            wdata_d  = PWDATA;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        abort_d = abort_now;
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        abort_d = abort_now;
        // HREADY=0 cycles are skipped, which also swallows the first cycle
        // of a two-cycle ERROR response.
        if (HREADY) begin
          if (!hwrite_q) prdata_d = HRDATA;
          pready_d  = ~abort_now;
          pslverr_d = HRESP & ~abort_now;
        end
      end
      ST_DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
      default: begin
        htrans_d = HTRANS_IDLE;
        pready_d = 1'b0;
      end
    endcase
  end

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HPROT     = hprot_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;

endmodule : mpsoc_apb42ahb3_master

// File: tb/tb_mpsoc_apb42ahb3_master.sv
// -----------------------------------------------------------------------------
// tb_mpsoc_apb42ahb3_master
// Directed bench for the APB4 to AHB3-Lite bridge. The initial block acts as
// both APB initiator and AHB slave; expected results are queued when each
// access is launched and compared once the bridge raises PREADY.
// -----------------------------------------------------------------------------
module tb_mpsoc_apb42ahb3_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [2:0]  PPROT = 3'b000;
  logic [3:0]  PSTRB = 4'b0000;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  always #5 HCLK = ~HCLK;

  mpsoc_apb42ahb3_master #(
    .PADDR_SIZE (32),
    .HADDR_SIZE (32),
    .DATA_SIZE  (32)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PPROT     (PPROT),
    .PSTRB     (PSTRB),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HMASTLOCK (HMASTLOCK),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    int          nonseq_n;
    int          pready_cyc;
    logic [31:0] prdata;
    logic        pslverr;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(bit wr, logic [31:0] haddr, logic [2:0] hsize,
                              logic [3:0] hprot, logic [31:0] hwdata, int nns,
                              int pcyc, logic [31:0] prdata, logic pslverr);
    exp_t e;
    e.wr = wr; e.haddr = haddr; e.hsize = hsize; e.hprot = hprot;
    e.hwdata = hwdata; e.nonseq_n = nns; e.pready_cyc = pcyc;
    e.prdata = prdata; e.pslverr = pslverr;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB access with an inline AHB slave: 'waits' wait states in the data
  // phase, optionally finishing with a two-cycle ERROR response.
  task automatic xfer(input string name, input bit wr, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wdata,
                      input logic [2:0] prot, input int waits, input bit err,
                      input logic [31:0] rdata, input exp_t e);
    exp_t        x;
    int          n_ns = 0, ns_cyc = -1, p_cyc = -1, wl = waits;
    bit          dph = 0, hw_rec = 0, err_sent = 0, seen = 0;
    logic [31:0] o_haddr = 'x, o_hwdata = 'x, o_prdata = 'x;
    logic [2:0]  o_hsize = 'x;
    logic [3:0]  o_hprot = 'x;
    logic        o_hwrite = 1'bx, o_pslverr = 1'bx;

    sb.push_back(e);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PSTRB = strb; PWDATA = wdata; PPROT = prot;
    HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK);   // access phase sampled here (cycle T)
    for (int c = 1; c <= 20; c++) begin
      @(negedge HCLK);
      if (HTRANS === 2'b10) begin
        n_ns++;
        if (ns_cyc < 0) begin
          ns_cyc = c; o_haddr = HADDR; o_hsize = HSIZE;
          o_hwrite = HWRITE; o_hprot = HPROT;
        end
      end
      if (dph && !hw_rec) begin
        o_hwdata = HWDATA; hw_rec = 1;
      end
      if (PREADY === 1'b1) begin
        seen = 1; p_cyc = c; o_prdata = PRDATA; o_pslverr = PSLVERR;
        break;
      end
      if (dph) begin
        if (wl > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; HRDATA = 32'hBAD0_0000 | 32'(c); wl--;
        end else if (err && !err_sent) begin
          HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hBAD1_0000 | 32'(c); err_sent = 1;
        end else begin
          HREADY = 1'b1; HRESP = err; HRDATA = rdata; dph = 0;
        end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
        if (HTRANS === 2'b10) dph = 1;
      end
    end

    x = sb.pop_front();
    chk({name, ":pready_seen"}, 32'(seen), 32'd1);
    chk({name, ":nonseq_count"}, 32'(n_ns), 32'(x.nonseq_n));
    if (x.nonseq_n > 0) begin
      chk({name, ":nonseq_cycle"}, 32'(ns_cyc), 32'd1);
      chk({name, ":haddr"}, o_haddr, x.haddr);
      chk({name, ":hsize"}, 32'(o_hsize), 32'(x.hsize));
      chk({name, ":hwrite"}, 32'(o_hwrite), 32'(x.wr));
      chk({name, ":hprot"}, 32'(o_hprot), 32'(x.hprot));
      if (x.wr) chk({name, ":hwdata"}, o_hwdata, x.hwdata);
    end
    chk({name, ":pready_cycle"}, 32'(p_cyc), 32'(x.pready_cyc));
    chk({name, ":pslverr"}, 32'(o_pslverr), 32'(x.pslverr));
    chk({name, ":prdata"}, o_prdata, x.prdata);
    $display("xfer %s wr=%0b addr=%h strb=%b nonseq=%0d pready_cyc=%0d prdata=%h pslverr=%b",
             name, wr, addr, strb, n_ns, p_cyc, o_prdata, o_pslverr);

    // APB completes on this edge; PREADY must then drop after one cycle.
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    chk({name, ":pready_pulse"}, 32'(PREADY), 32'd0);
    chk({name, ":pslverr_clear"}, 32'(PSLVERR), 32'd0);
    chk({name, ":htrans_idle_after"}, 32'(HTRANS), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst:htrans", 32'(HTRANS), 32'd0);
    chk("rst:haddr", HADDR, 32'd0);
    chk("rst:hwdata", HWDATA, 32'd0);
    chk("rst:hwrite", 32'(HWRITE), 32'd0);
    chk("rst:hsize", 32'(HSIZE), 32'd2);
    chk("rst:hprot", 32'(HPROT), 32'd3);
    chk("rst:prdata", PRDATA, 32'd0);
    chk("rst:pready", 32'(PREADY), 32'd0);
    chk("rst:pslverr", 32'(PSLVERR), 32'd0);
    chk("rst:hburst", 32'(HBURST), 32'd0);
    chk("rst:hmastlock", 32'(HMASTLOCK), 32'd0);
    HRESETn = 1'b1;

    // Zero-wait word write: NONSEQ at T+1, HWDATA at T+2, PREADY at T+3.
    xfer("wr_word", 1, 32'h100, 4'b1111, 32'hDEADBEEF, 3'b000, 0, 0, 32'h0,
         mk(1, 32'h100, 3'b010, 4'b0001, 32'hDEADBEEF, 1, 3, 32'h0, 0));
    // Word read with two wait states: PREADY at T+5.
    xfer("rd_wait2", 0, 32'h104, 4'b0000, 32'h0, 3'b101, 2, 0, 32'h12345678,
         mk(0, 32'h104, 3'b010, 4'b0010, 32'h0, 1, 5, 32'h12345678, 0));
    // Byte and halfword writes; PADDR[1:0] replaced by the strobe offset.
    xfer("wr_byte2", 1, 32'h203, 4'b0100, 32'h00AB0000, 3'b010, 0, 0, 32'h0,
         mk(1, 32'h202, 3'b000, 4'b0001, 32'h00AB0000, 1, 3, 32'h12345678, 0));
    xfer("wr_half2", 1, 32'h203, 4'b1100, 32'hCDEF0000, 3'b001, 0, 0, 32'h0,
         mk(1, 32'h202, 3'b001, 4'b0011, 32'hCDEF0000, 1, 3, 32'h12345678, 0));
    xfer("wr_byte3_w1", 1, 32'h200, 4'b1000, 32'h77000000, 3'b100, 1, 0, 32'h0,
         mk(1, 32'h203, 3'b000, 4'b0000, 32'h77000000, 1, 4, 32'h12345678, 0));
    xfer("wr_half0", 1, 32'h40A, 4'b0011, 32'h00005A5A, 3'b000, 0, 0, 32'h0,
         mk(1, 32'h408, 3'b001, 4'b0001, 32'h00005A5A, 1, 3, 32'h12345678, 0));
    // Illegal strobes: no AHB transfer, PSLVERR with PREADY at T+1.
    xfer("wr_illegal_0101", 1, 32'h300, 4'b0101, 32'h11111111, 3'b000, 0, 0, 32'h0,
         mk(1, 32'h0, 3'b010, 4'b0001, 32'h0, 0, 1, 32'h12345678, 1));
    xfer("wr_illegal_0000", 1, 32'h300, 4'b0000, 32'h22222222, 3'b000, 0, 0, 32'h0,
         mk(1, 32'h0, 3'b010, 4'b0001, 32'h0, 0, 1, 32'h12345678, 1));
    // Two-cycle ERROR on a read: single NONSEQ, PSLVERR with PREADY at T+4.
    xfer("rd_error", 0, 32'h500, 4'b1111, 32'h0, 3'b001, 0, 1, 32'hCAFEF00D,
         mk(0, 32'h500, 3'b010, 4'b0011, 32'h0, 1, 4, 32'hCAFEF00D, 1));

    // Reset asserted while the bridge sits in the data phase.
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h600; PPROT = 3'b001;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    chk("rstmid:nonseq", 32'(HTRANS), 32'd2);
    HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;   // hold the data phase
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rstmid:htrans", 32'(HTRANS), 32'd0);
    chk("rstmid:pready", 32'(PREADY), 32'd0);
    chk("rstmid:haddr", HADDR, 32'd0);
    chk("rstmid:hsize", 32'(HSIZE), 32'd2);
    chk("rstmid:prdata", PRDATA, 32'd0);
    $display("xfer rstmid reset pulsed during data phase htrans=%b pready=%b", HTRANS, PREADY);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1; HREADY = 1'b1;

    // Bridge recovers and completes a normal read.
    xfer("rd_after_rst", 0, 32'h008, 4'b0000, 32'h0, 3'b000, 0, 0, 32'hA5A55A5A,
         mk(0, 32'h008, 3'b010, 4'b0001, 32'h0, 1, 3, 32'hA5A55A5A, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mpsoc_apb42ahb3_master

// File: doc/mpsoc_apb42ahb3_master.md
Name: mpsoc_apb42ahb3_master

Overview:
APB4 slave to AHB3-Lite master bridge, the reverse direction of the existing AHB3-to-APB4 bridge. An APB4 initiator (debug/config master) reaches AHB-Lite memory-mapped slaves through it. Each APB4 access becomes exactly one AHB-Lite SINGLE transfer, or an immediate PSLVERR on an illegal strobe. Single clock domain; no FIFOs; one outstanding transfer.

Parameters:
PADDR_SIZE, 32, APB address width; zero-extended or truncated to HADDR_SIZE
HADDR_SIZE, 32, AHB address width
DATA_SIZE, 32, data width of both buses; only 32 is supported (elaboration error otherwise)

Ports:
HCLK  in  1  clock for both sides
HRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB direction
PPROT  in  3  APB protection
PSTRB  in  4  APB write byte strobes
PADDR  in  PADDR_SIZE  APB address
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data, registered
PREADY  out  1  APB ready, registered one-cycle pulse
PSLVERR  out  1  APB error, valid with PREADY
HADDR  out  HADDR_SIZE  AHB address
HWDATA  out  32  AHB write data
HRDATA  in  32  AHB read data
HWRITE  out  1  AHB direction
HSIZE  out  3  AHB size
HBURST  out  3  constant 3'b000 (SINGLE)
HPROT  out  4  AHB protection
HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
HMASTLOCK  out  1  constant 0
HREADY  in  1  AHB ready from the slave mux
HRESP  in  1  AHB response (0 OKAY, 1 ERROR)

Behaviour:
- Reset (async assert, sync deassert by the system): state IDLE, HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=3'b010, HPROT=4'b0011, PRDATA=0, PREADY=0, PSLVERR=0.
- All AHB and APB outputs are registered.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: on PSEL&PENABLE, latch the request and decode the strobe.
  - Legal strobe: -> ADDR.
  - Illegal strobe: -> DONE with PSLVERR=1 and no AHB transfer.
- Strobe decode. HADDR = {PADDR[HADDR_SIZE-1:2], off}; PADDR[1:0] are ignored.
  - Read (PWRITE=0, PSTRB ignored): word access, off=0, HSIZE=010.
  - 0001/0010/0100/1000: byte, off=0/1/2/3, HSIZE=000.
  - 0011/1100: half, off=0/2, HSIZE=001.
  - 1111: word, off=0, HSIZE=010.
  - Any other value, including a 0000 write: illegal.
- HPROT = {2'b00, PPROT[0], ~PPROT[2]}; PPROT[1] is ignored.
- ADDR: HTRANS=NONSEQ with HADDR/HWRITE/HSIZE held. When HREADY=1, drive HTRANS=IDLE and HWDATA=latched PWDATA, then -> DATA.
- DATA: HWDATA held. On HREADY=1:
  - capture PRDATA=HRDATA (reads only; PRDATA holds its previous value on writes);
  - PSLVERR=HRESP;
  - -> DONE.
  - Cycles with HREADY=0 are ignored, which absorbs the first cycle of the two-cycle ERROR response.
- DONE: PREADY=1 for exactly one cycle, then -> IDLE with PREADY=0 and PSLVERR=0.
- Latency with a zero-wait slave: access phase seen at cycle T; NONSEQ at T+1; data phase at T+2; PREADY at T+3. Each AHB wait state adds one cycle. An illegal strobe gives PREADY at T+1.
- The IDLE->ADDR transition is blocked while PREADY=1, so an APB access phase held after completion is not re-issued.
- PSEL deasserted mid-transfer (protocol violation): the AHB transfer still completes and PREADY is suppressed.
- HRESETn asserted mid-transfer: immediate return to reset values. HTRANS=IDLE is acceptable to AHB-Lite slaves.

Decomposition:
- Package mpsoc_apb42ahb3_master_pkg holds:
  - the state enum;
  - HTRANS_IDLE/HTRANS_NONSEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HBURST_SINGLE.
- Sub-module mpsoc_apb4_strb_decode is combinational. Inputs: PWRITE, PSTRB. Outputs: legal, hsize, off[1:0].

Test Plan:
- Write PADDR=0x100, PSTRB=1111, PWDATA=0xDEADBEEF, zero-wait slave -> NONSEQ at T+1 with HADDR=0x100, HSIZE=010, HWRITE=1; HWDATA=0xDEADBEEF at T+2; PREADY=1 at T+3 with PSLVERR=0.
- Read PADDR=0x104, slave inserts 2 wait states and returns HRDATA=0x12345678 -> PREADY at T+5 with PRDATA=0x12345678.
- Write PSTRB=0100 then 1100 at PADDR=0x203 -> HADDR=0x202/HSIZE=000, then HADDR=0x202/HSIZE=001.
- Write PSTRB=0101 -> HTRANS stays IDLE throughout; PREADY=1 and PSLVERR=1 at T+1.
- Read where the slave gives a two-cycle ERROR -> PSLVERR=1 with PREADY, and exactly one NONSEQ observed.
- HRESETn pulsed low while in DATA -> HTRANS=IDLE and PREADY=0 immediately; the next APB read completes normally.
